// File: rtl/writeback_router.sv
// Write-back router: steers each ALU result to the register file, a memory
// store (req/ack with timeout), the output port register, or discards it.
module writeback_router #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 8,
  parameter int RF_ADDR_WIDTH    = 3,
  parameter int DEST_SELECT_BITS = 2,
  parameter int MEM_TIMEOUT      = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [DEST_SELECT_BITS-1:0] in_dest,
  input  logic [RF_ADDR_WIDTH-1:0]    in_rf_addr,
  input  logic [ADDR_WIDTH-1:0]       in_mem_addr,
  output logic                        rf_we,
  output logic [RF_ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]       rf_wdata,
  output logic                        mem_req,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic                        mem_ack,
  output logic [DATA_WIDTH-1:0]       out_port,
  output logic                        out_strobe,
  output logic                        err_timeout,
  output logic [7:0]                  wb_count
);

  localparam logic [DEST_SELECT_BITS-1:0] DEST_RF   = DEST_SELECT_BITS'(0);
  localparam logic [DEST_SELECT_BITS-1:0] DEST_MEM  = DEST_SELECT_BITS'(1);
  localparam logic [DEST_SELECT_BITS-1:0] DEST_PORT = DEST_SELECT_BITS'(2);
  localparam logic [7:0]                  TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       xfer;
  logic       store_done;
  logic       store_abort;

  assign xfer        = in_valid && in_ready;
  assign store_done  = (state == MEM_WAIT) && mem_ack;
  // The abort edge is the one that finds the counter already at the limit,
  // so mem_req stays high for MEM_TIMEOUT+1 cycles.
  assign store_abort = (state == MEM_WAIT) && !mem_ack && (wait_cnt == TIMEOUT_VAL);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (xfer && in_dest == DEST_MEM) state_next = MEM_WAIT;
      MEM_WAIT: if (store_done || store_abort)   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Ready is a pure state decode, keeping in_valid off any combinational path.
  always_comb begin
    in_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      out_port    <= '0;
      out_strobe  <= 1'b0;
      err_timeout <= 1'b0;
      wb_count    <= '0;
      wait_cnt    <= '0;
    end else begin
      rf_we      <= xfer && (in_dest == DEST_RF);
      out_strobe <= xfer && (in_dest == DEST_PORT);

      if (xfer && in_dest == DEST_RF) begin
        rf_waddr <= in_rf_addr;
        rf_wdata <= in_data;
      end

      if (xfer && in_dest == DEST_PORT) out_port <= in_data;

      if (xfer && in_dest == DEST_MEM) begin
        mem_req   <= 1'b1;
        mem_addr  <= in_mem_addr;
        mem_wdata <= in_data;
        wait_cnt  <= '0;
      end else if (store_done) begin
        mem_req <= 1'b0;
      end else if (store_abort) begin
        mem_req     <= 1'b0;
        err_timeout <= 1'b1;
      end else if (state == MEM_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // Abandoned stores are deliberately not counted.
      if ((xfer && in_dest != DEST_MEM) || store_done) wb_count <= wb_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_writeback_router.sv
// Self-checking bench for writeback_router: directed scenarios plus a random
// transaction mix scored against a transaction-level expectation model.
module tb_writeback_router;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [1:0] in_dest = '0;
  logic [2:0] in_rf_addr = '0;
  logic [7:0] in_mem_addr = '0;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] out_port;
  logic       out_strobe;
  logic       err_timeout;
  logic [7:0] wb_count;

  int checks = 0;
  int errors = 0;

  // Expectation model: what the outside world should observe, per transaction.
  logic [7:0] m_wb  = '0;
  logic [7:0] m_out = '0;
  logic       m_err = 1'b0;

  writeback_router #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .RF_ADDR_WIDTH(3),
    .DEST_SELECT_BITS(2), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_rf_addr(in_rf_addr), .in_mem_addr(in_mem_addr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .out_port(out_port), .out_strobe(out_strobe),
    .err_timeout(err_timeout), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One non-store transfer driven at the current negedge, checked one edge later.
  task automatic send(input logic [1:0] dest, input logic [7:0] data, input logic [2:0] rfa);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL send_ready: in_ready=%b expected 1", in_ready);
    end
    in_valid = 1'b1; in_dest = dest; in_data = data; in_rf_addr = rfa;
    in_mem_addr = 8'($urandom);
    tick();
    in_valid = 1'b0; in_data = 8'($urandom);
    m_wb = m_wb + 8'd1;
    if (dest == 2'b10) m_out = data;
    checks++;
    if (rf_we !== (dest == 2'b00)) begin
      errors++; $display("FAIL send_rf_we: rf_we=%b expected %b (dest %b)", rf_we, dest == 2'b00, dest);
    end
    if (dest == 2'b00) begin
      checks++;
      if (rf_waddr !== rfa || rf_wdata !== data) begin
        errors++; $display("FAIL send_rf_data: addr=%0d data=%h expected addr=%0d data=%h",
                           rf_waddr, rf_wdata, rfa, data);
      end
    end
    checks++;
    if (out_strobe !== (dest == 2'b10)) begin
      errors++; $display("FAIL send_strobe: out_strobe=%b expected %b (dest %b)", out_strobe, dest == 2'b10, dest);
    end
    checks++;
    if (out_port !== m_out) begin
      errors++; $display("FAIL send_out_port: out_port=%h expected %h", out_port, m_out);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL send_mem_req: mem_req=%b expected 0", mem_req);
    end
    checks++;
    if (wb_count !== m_wb || err_timeout !== m_err) begin
      errors++; $display("FAIL send_counters: wb_count=%0d err=%b expected wb_count=%0d err=%b",
                         wb_count, err_timeout, m_wb, m_err);
    end
  endtask

  // ack_cycle = mem_req cycle in which mem_ack is raised; outside 1..TMO+1 means never.
  task automatic store(input logic [7:0] addr, input logic [7:0] data, input int ack_cycle);
    int  n = 0;
    int  exp_n;
    bit  done = 0;
    bit  acked;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL store_ready_in: in_ready=%b expected 1", in_ready);
    end
    in_valid = 1'b1; in_dest = 2'b01; in_mem_addr = addr; in_data = data;
    in_rf_addr = 3'($urandom);
    tick();
    in_valid = 1'b0; in_data = 8'($urandom); in_mem_addr = 8'($urandom);
    for (int c = 1; c <= 40 && !done; c++) begin
      if (mem_req === 1'b1) begin
        n++;
        checks++;
        if (mem_addr !== addr || mem_wdata !== data) begin
          errors++; $display("FAIL store_stable: cycle %0d addr=%h data=%h expected addr=%h data=%h",
                             c, mem_addr, mem_wdata, addr, data);
        end
        checks++;
        if (in_ready !== 1'b0 || rf_we !== 1'b0 || out_strobe !== 1'b0) begin
          errors++; $display("FAIL store_quiet: cycle %0d in_ready=%b rf_we=%b strobe=%b expected 0 0 0",
                             c, in_ready, rf_we, out_strobe);
        end
        mem_ack = (c == ack_cycle);
        tick();
      end else begin
        done = 1;
      end
    end
    mem_ack = 1'b0;
    acked = (ack_cycle >= 1 && ack_cycle <= TMO + 1);
    exp_n = acked ? ack_cycle : TMO + 1;
    if (acked) m_wb = m_wb + 8'd1;
    else       m_err = 1'b1;
    checks++;
    if (n !== exp_n) begin
      errors++; $display("FAIL store_len: mem_req high %0d cycles, expected %0d", n, exp_n);
    end
    checks++;
    if (in_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL store_release: in_ready=%b mem_req=%b expected 1 0", in_ready, mem_req);
    end
    checks++;
    if (wb_count !== m_wb || err_timeout !== m_err) begin
      errors++; $display("FAIL store_counters: wb_count=%0d err=%b expected wb_count=%0d err=%b",
                         wb_count, err_timeout, m_wb, m_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_wdata,
         out_port, out_strobe, err_timeout, wb_count} !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_values: outputs not at reset values (in_ready=%b wb=%0d mem_req=%b)",
                         in_ready, wb_count, mem_req);
    end
    rst_n = 1'b1;
    m_wb = '0; m_out = '0; m_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    send(2'b00, 8'h11, 3'd1);
    send(2'b00, 8'h22, 3'd2);
    send(2'b00, 8'h33, 3'd3);
    tick();
    checks++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1 || wb_count !== 8'd3) begin
      errors++; $display("FAIL b2b_tail: rf_we=%b in_ready=%b wb=%0d expected 0 1 3", rf_we, in_ready, wb_count);
    end
  endtask

  task automatic test_store_ack();
    store(8'h40, 8'hA5, 3);
  endtask

  task automatic test_timeout();
    store(8'h81, 8'h3D, 0);
    tick();
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: err_timeout=%b expected 1", err_timeout);
    end
    send(2'b10, 8'h5C, 3'($urandom));
  endtask

  task automatic test_out_port();
    send(2'b10, 8'h7E, 3'($urandom));
    send(2'b11, 8'hFF, 3'($urandom));
    tick();
    checks++;
    if (out_port !== 8'h7E || out_strobe !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL port_hold: out_port=%h strobe=%b rf_we=%b expected 7e 0 0",
                         out_port, out_strobe, rf_we);
    end
  endtask

  task automatic test_reset_mid_store();
    in_valid = 1'b1; in_dest = 2'b01; in_mem_addr = 8'h66; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: mem_req=%b expected 1 in 2nd store cycle", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_wdata,
         out_port, out_strobe, err_timeout, wb_count} !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_async: mem_req=%b wb=%0d err=%b in_ready=%b expected reset values",
                         mem_req, wb_count, err_timeout, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_wb = '0; m_out = '0; m_err = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL midrst_after: in_ready=%b mem_req=%b expected 1 0", in_ready, mem_req);
    end
  endtask

  task automatic test_stall();
    int accept_c = -1;
    int we_c = -1;
    int pulses = 0;
    in_valid = 1'b1; in_dest = 2'b01; in_mem_addr = 8'h22; in_data = 8'h3C;
    tick();
    in_dest = 2'b00; in_rf_addr = 3'd5; in_data = 8'h99;
    for (int c = 1; c <= 8; c++) begin
      if (rf_we === 1'b1) begin
        pulses++; we_c = c;
        checks++;
        if (rf_waddr !== 3'd5 || rf_wdata !== 8'h99) begin
          errors++; $display("FAIL stall_rf_data: addr=%0d data=%h expected 5 99", rf_waddr, rf_wdata);
        end
      end
      mem_ack = (mem_req === 1'b1) && (c == 2);
      if (in_valid && in_ready === 1'b1) accept_c = c;
      tick();
      if (accept_c == c) in_valid = 1'b0;
    end
    mem_ack = 1'b0;
    in_valid = 1'b0;
    m_wb = m_wb + 8'd2;
    checks++;
    if (accept_c != 3) begin
      errors++; $display("FAIL stall_accept: accepted in cycle %0d, expected 3 (after ack)", accept_c);
    end
    checks++;
    if (pulses != 1 || we_c != accept_c + 1) begin
      errors++; $display("FAIL stall_rf_we: %0d pulses at cycle %0d, expected 1 at cycle %0d",
                         pulses, we_c, accept_c + 1);
    end
    checks++;
    if (wb_count !== m_wb) begin
      errors++; $display("FAIL stall_count: wb_count=%0d expected %0d", wb_count, m_wb);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [1:0] d;
      d = 2'($urandom);
      if (d == 2'b01) store(8'($urandom), 8'($urandom), int'($urandom_range(0, 20)));
      else            send(d, 8'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_store_ack();
    test_timeout();
    test_out_port();
    test_reset_mid_store();
    test_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_router.md
Name: writeback_router

Overview:
- Write-back end of the 8-bit datapath. The operand-select mux feeds the ALU from the register file, memory or an immediate; this block takes the ALU result and routes it back out.
- Destinations: a register-file write, a memory store (req/ack handshake), the output port register, or discard.
- Accepts one result per cycle. It stalls the producer while a memory store is outstanding.

Parameters:
- DATA_WIDTH, 8, width of result, register-file data, memory data and out port.
- ADDR_WIDTH, 8, memory address width.
- RF_ADDR_WIDTH, 3, register-file address width.
- DEST_SELECT_BITS, 2, destination select width.
- MEM_TIMEOUT, 15, number of waiting cycles without mem_ack before a store is abandoned. Must be 1 to 255.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  result present.
- in_ready  output  1  router can accept.
- in_data  input  DATA_WIDTH  result value.
- in_dest  input  DEST_SELECT_BITS  destination: 00 register file, 01 memory, 10 out port, 11 discard.
- in_rf_addr  input  RF_ADDR_WIDTH  register-file destination register.
- in_mem_addr  input  ADDR_WIDTH  memory store address.
- rf_we  output  1  register-file write enable, one-cycle pulse.
- rf_waddr  output  RF_ADDR_WIDTH  register-file write address.
- rf_wdata  output  DATA_WIDTH  register-file write data.
- mem_req  output  1  store request.
- mem_addr  output  ADDR_WIDTH  store address.
- mem_wdata  output  DATA_WIDTH  store data.
- mem_ack  input  1  store completed, sampled on the clock edge.
- out_port  output  DATA_WIDTH  registered output port value.
- out_strobe  output  1  out_port updated, one-cycle pulse.
- err_timeout  output  1  sticky memory timeout flag.
- wb_count  output  8  count of completed write-backs, wraps.

Behaviour:
- Handshake: a transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_ready = 1 in IDLE, 0 in MEM_WAIT. It is purely state-decoded, with no combinational path from in_valid.
- Reset values while rst_n=0 (asynchronous):
  - state = IDLE.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - mem_req = 0, mem_addr = 0, mem_wdata = 0.
  - out_port = 0, out_strobe = 0.
  - err_timeout = 0, wb_count = 0, wait counter = 0.
  - in_ready = 1.
- State IDLE, transfer with dest 00:
  - Next cycle: rf_we = 1, rf_waddr = in_rf_addr, rf_wdata = in_data. Latency 1.
  - Stay in IDLE. Back-to-back transfers produce rf_we high on consecutive cycles.
- State IDLE, transfer with dest 01:
  - Register in_mem_addr and in_data onto mem_addr and mem_wdata. Set mem_req = 1. Clear the wait counter. Go to MEM_WAIT.
- State IDLE, transfer with dest 10:
  - Next cycle: out_port = in_data, out_strobe = 1. out_port holds until the next dest-10 transfer.
- State IDLE, transfer with dest 11: no output activity.
- State IDLE, no transfer: rf_we = 0, out_strobe = 0.
- wb_count increments by 1 (mod 256) per accepted dest-00, dest-10 or dest-11 transfer, and per acknowledged store. A timed-out store does not count.
- State MEM_WAIT:
  - mem_req stays 1. mem_addr and mem_wdata stay stable.
  - rf_we = 0, out_strobe = 0.
  - On an edge with mem_ack = 1: mem_req goes 0 and state returns to IDLE. in_ready is 1 in the following cycle.
  - mem_ack asserted in the first mem_req cycle is valid, giving a minimum of 1 mem_req-high cycle.
  - On an edge with mem_ack = 0: the wait counter increments. When the counter reaches MEM_TIMEOUT: mem_req goes 0, err_timeout is set to 1, state returns to IDLE.
  - A store therefore holds mem_req for at most MEM_TIMEOUT+1 cycles before being abandoned.
- mem_ack in IDLE is ignored.
- err_timeout clears only on reset. Processing continues normally after a timeout.
- If reset asserts mid-store, mem_req drops immediately and the store is lost. After reset the block is in IDLE.
- Inputs are don't-care when in_valid = 0.
- Unused or undefined select values: not applicable, all four codes are defined.

Test Plan:
- Reset, then 3 back-to-back dest-00 transfers (addr 1/2/3, data 0x11/0x22/0x33).
  - Required: rf_we high for exactly 3 consecutive cycles, each 1 cycle after its transfer, with matching addr and data.
  - Required: in_ready stays 1; wb_count = 3.
- Dest-01 transfer (addr 0x40, data 0xA5) with mem_ack raised in the 3rd mem_req cycle.
  - Required: mem_req high for exactly 3 cycles with addr 0x40 and data 0xA5 stable.
  - Required: in_ready low for those 3 cycles; wb_count +1; err_timeout = 0.
- Dest-01 transfer with mem_ack never asserted, MEM_TIMEOUT = 15.
  - Required: mem_req high for 16 cycles, then low; err_timeout = 1 and remains 1; wb_count unchanged.
  - Then a dest-10 transfer with data 0x5C. Required: out_port = 0x5C and out_strobe pulses.
- Dest-10 transfer 0x7E followed by dest-11 transfer 0xFF.
  - Required: out_port = 0x7E after the first and stays 0x7E; out_strobe pulses once.
  - Required: no rf_we or mem_req activity; wb_count +2.
- Dest-01 transfer, then rst_n pulled low for 1 cycle during the 2nd mem_req cycle.
  - Required: mem_req falls asynchronously; all outputs return to reset values; in_ready = 1 after reset release.
- Dest-01 store is pending while in_valid is held high with a dest-00 result (addr 5, data 0x99).
  - Required: the dest-00 result is not accepted until after mem_ack.
  - Required: rf_we pulses exactly once, 1 cycle after the accepting edge, with addr 5 and data 0x99.
